// File: rtl/mppc_pkg.sv
// Shared constants and state type for the MPPC hit counter and its input stage.
package mppc_pkg;

   localparam int unsigned MPPC_COUNT_W    = 8;
   localparam int unsigned MPPC_CLK_HZ     = 9_600_000;
   localparam int unsigned MPPC_WINDOW_1MS = MPPC_CLK_HZ / 1000;

   typedef enum logic {
      IDLE,
      COUNT
   } mppc_cnt_state_t;

endpackage

// File: rtl/mppc_pulse_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous level input.
// The third flop only remembers the previous synchronized level for edge detection.
module mppc_pulse_sync (
   input  logic CLK,
   input  logic RST,
   input  logic async_in,
   output logic rise
);

   logic [2:0] sync_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mppc_hit_counter.sv
// Gated MPPC hit counter: counts discriminator edges per window and hands each
// window's saturating count out over valid/ready. Dead-time masking: MPPC_DEADTIME_EN.
module mppc_hit_counter
   import mppc_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES   = MPPC_WINDOW_1MS,
   parameter int unsigned DEADTIME_CYCLES = 8,
   parameter int unsigned COUNT_W         = MPPC_COUNT_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               DISC,
   input  logic               ENABLE,
   output logic [COUNT_W-1:0] DATA,
   output logic               DATA_VALID,
   input  logic               DATA_READY,
   output logic               OVERRUN
);

   localparam logic [15:0]        WIN_LAST = 16'(WINDOW_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

   if (WINDOW_CYCLES < 2 || WINDOW_CYCLES > 65535 || DEADTIME_CYCLES < 1 ||
       DEADTIME_CYCLES > 255 || COUNT_W != MPPC_COUNT_W) begin : g_bad_param
      $error("mppc_hit_counter: parameter out of legal range");
   end

   mppc_cnt_state_t    state_q, state_d;
   logic [15:0]        win_q, win_d;
   logic [COUNT_W-1:0] hit_q, hit_d, hit_next;
   logic [COUNT_W-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               overrun_q, overrun_d;
   logic               rise, hit, counting, win_close, xfer, load;

   mppc_pulse_sync u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in (DISC),
      .rise     (rise)
   );

   assign counting = (state_q == COUNT) && ENABLE;

`ifdef MPPC_DEADTIME_EN
   logic [7:0] dead_q, dead_d;

   // Counter reaching 0 reopens the gate in the same cycle.
   assign hit = rise && (dead_q == 8'd0);

   always_comb begin
      dead_d = dead_q;
      if (!counting) begin
         dead_d = 8'd0;
      end else if (hit) begin
         dead_d = 8'(DEADTIME_CYCLES);
      end else if (dead_q != 8'd0) begin
         dead_d = dead_q - 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dead_q <= 8'd0;
      end else begin
         dead_q <= dead_d;
      end
   end
`else
   assign hit = rise;
`endif

   always_ff @(posedge CLK) begin : state_reg
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ENABLE) state_d = COUNT;
         COUNT:   if (!ENABLE) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A hit in the terminal cycle still belongs to the closing window.
   assign hit_next  = (hit && (hit_q != CNT_MAX)) ? hit_q + COUNT_W'(1) : hit_q;
   assign win_close = counting && (win_q == WIN_LAST);
   assign xfer      = valid_q && DATA_READY;
   assign load      = win_close && (!valid_q || DATA_READY);

   always_comb begin : datapath
      win_d = '0;
      hit_d = '0;
      if (counting && !win_close) begin
         win_d = win_q + 16'd1;
         hit_d = hit_next;
      end
      data_d    = load ? hit_next : data_q;
      valid_d   = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
      overrun_d = overrun_q | (win_close && !load);
   end

   always_ff @(posedge CLK) begin : data_regs
      if (RST) begin
         win_q     <= '0;
         hit_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         win_q     <= win_d;
         hit_q     <= hit_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin : outputs
      DATA       = data_q;
      DATA_VALID = valid_q;
      OVERRUN    = overrun_q;
   end

endmodule

// File: tb/tb_mppc_hit_counter.sv
// Self-checking bench for mppc_hit_counter against a timestamp-based window model.
// Honours MPPC_DEADTIME_EN in the model when the design is built with it.
module tb_mppc_hit_counter;

   localparam int W    = 100;
   localparam int D    = 8;
   localparam int WSAT = 1300;
`ifdef MPPC_DEADTIME_EN
   localparam bit DT_ON = 1'b1;
`else
   localparam bit DT_ON = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST, DISC, ENABLE, DATA_READY;
   logic [7:0] DATA, SAT_DATA;
   logic       DATA_VALID, OVERRUN, SAT_VALID, SAT_OVERRUN;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   mppc_hit_counter #(.WINDOW_CYCLES(W), .DEADTIME_CYCLES(D), .COUNT_W(8)) dut (
      .CLK(CLK), .RST(RST), .DISC(DISC), .ENABLE(ENABLE), .DATA(DATA),
      .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .OVERRUN(OVERRUN)
   );

   // Long window so a saturating burst fits inside one window.
   mppc_hit_counter #(.WINDOW_CYCLES(WSAT), .DEADTIME_CYCLES(D), .COUNT_W(8)) dut_sat (
      .CLK(CLK), .RST(RST), .DISC(DISC), .ENABLE(ENABLE), .DATA(SAT_DATA),
      .DATA_VALID(SAT_VALID), .DATA_READY(DATA_READY), .OVERRUN(SAT_OVERRUN)
   );

   // Model: hits are timestamps; a window is a run of W edges after enable.
   int m_time = 0;
   bit m_h0, m_h1, m_h2;
   bit m_run, m_valid, m_over;
   int m_pos, m_hits, m_last, m_data;

   function automatic bit train(int k, int start, int n, int period, int high);
      return (k >= start) && (k < start + n * period) && (((k - start) % period) < high);
   endfunction

   function automatic int exp_regular(int n, int period);
      int cnt  = 0;
      int last = -1000;
      for (int i = 0; i < n; i++) begin
         if (!DT_ON || (i * period - last > D)) begin
            cnt++;
            last = i * period;
         end
      end
      return (cnt > 255) ? 255 : cnt;
   endfunction

   task automatic cyc(input bit rst, input bit en, input bit disc, input bit rdy);
      bit cand, xfer, load;
      RST = rst; ENABLE = en; DISC = disc; DATA_READY = rdy;
      @(posedge CLK);
      cand = m_h1 && !m_h2;
      if (rst) begin
         {m_h0, m_h1, m_h2} = 3'b000;
         m_run = 0; m_pos = 0; m_hits = 0; m_last = -1000;
         m_valid = 0; m_data = 0; m_over = 0;
      end else begin
         xfer = m_valid && rdy;
         load = 0;
         if (!m_run) begin
            if (en) begin
               m_run = 1; m_pos = 0; m_hits = 0; m_last = -1000;
            end
         end else if (!en) begin
            m_run = 0;
         end else begin
            if (cand && (!DT_ON || (m_time - m_last > D))) begin
               m_hits++;
               m_last = m_time;
            end
            if (m_pos == W - 1) begin
               if (!m_valid || xfer) begin
                  load = 1; m_valid = 1;
                  m_data = (m_hits > 255) ? 255 : m_hits;
               end else begin
                  m_over = 1;
               end
               m_pos = 0; m_hits = 0;
            end else begin
               m_pos++;
            end
         end
         if (!load && xfer) m_valid = 0;
         m_h2 = m_h1; m_h1 = m_h0; m_h0 = disc;
      end
      m_time++;
      #1;
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0);
      cyc(1, 1, 1, 1);
      checks++;
      if (DATA !== 8'd0 || DATA_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs data=%0d valid=%b ovr=%b required 0/0/0",
                  DATA, DATA_VALID, OVERRUN);
      end
      checks++;
      if (SAT_DATA !== 8'd0 || SAT_VALID !== 1'b0 || SAT_OVERRUN !== 1'b0) begin
         failures++;
         $display("FAIL reset_sat_outputs data=%0d valid=%b ovr=%b required 0/0/0",
                  SAT_DATA, SAT_VALID, SAT_OVERRUN);
      end
      for (int k = 0; k < 20; k++) cyc(0, 0, k[2], 1);
      checks++;
      if (DATA_VALID !== 1'b0 || DATA !== 8'd0) begin
         failures++;
         $display("FAIL idle_no_word valid=%b data=%0d required 0/0", DATA_VALID, DATA);
      end
   endtask

   task automatic test_clean_pulses();
      int nvalid = 0;
      int vdata  = -1;
      int vk     = -1;
      do_reset();
      cyc(0, 1, 0, 1);
      for (int k = 1; k <= 115; k++) begin
         cyc(0, 1, train(k, 10, 5, 20, 4), 1);
         checks++;
         if (DATA_VALID !== m_valid || OVERRUN !== m_over || DATA !== 8'(m_data)) begin
            failures++;
            $display("FAIL clean_model k=%0d valid=%b/%b data=%0d/%0d ovr=%b/%b (actual/required)",
                     k, DATA_VALID, m_valid, DATA, m_data, OVERRUN, m_over);
         end
         if (DATA_VALID === 1'b1) begin
            nvalid++; vdata = DATA; vk = k;
         end
      end
      checks++;
      if (nvalid != 1 || vdata != 5 || vk != W) begin
         failures++;
         $display("FAIL clean_word pulses=%0d data=%0d at=%0d required 1/5/%0d",
                  nvalid, vdata, vk, W);
      end
   endtask

   task automatic test_saturation();
      int exp_sat = exp_regular(300, 4);
      int nsat    = 0;
      int d1      = -1;
      int d2      = -1;
      do_reset();
      cyc(0, 1, 0, 1);
      for (int k = 1; k <= 2 * WSAT + 5; k++) begin
         cyc(0, 1, train(k, 5, 300, 4, 2), 1);
         checks++;
         if (DATA_VALID !== m_valid || OVERRUN !== m_over || DATA !== 8'(m_data)) begin
            failures++;
            $display("FAIL sat_main_model k=%0d valid=%b/%b data=%0d/%0d ovr=%b/%b (actual/required)",
                     k, DATA_VALID, m_valid, DATA, m_data, OVERRUN, m_over);
         end
         if (SAT_VALID === 1'b1) begin
            nsat++;
            if (k == WSAT) d1 = SAT_DATA;
            if (k == 2 * WSAT) d2 = SAT_DATA;
         end
      end
      checks++;
      if (d1 != exp_sat) begin
         failures++;
         $display("FAIL sat_count data=%0d required %0d", d1, exp_sat);
      end
      checks++;
      if (d2 != 0 || nsat != 2 || SAT_OVERRUN !== 1'b0) begin
         failures++;
         $display("FAIL sat_next_window data=%0d words=%0d ovr=%b required 0/2/0",
                  d2, nsat, SAT_OVERRUN);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      cyc(0, 1, 0, 0);
      for (int k = 1; k <= 2 * W; k++) begin
         cyc(0, 1, (k <= W) ? train(k, 10, 3, 10, 2) : train(k, W + 10, 7, 10, 2), 0);
         checks++;
         if (DATA_VALID !== m_valid || OVERRUN !== m_over || DATA !== 8'(m_data)) begin
            failures++;
            $display("FAIL ovr_model k=%0d valid=%b/%b data=%0d/%0d ovr=%b/%b (actual/required)",
                     k, DATA_VALID, m_valid, DATA, m_data, OVERRUN, m_over);
         end
      end
      checks++;
      if (DATA !== 8'd3 || DATA_VALID !== 1'b1 || OVERRUN !== 1'b1) begin
         failures++;
         $display("FAIL ovr_hold data=%0d valid=%b ovr=%b required 3/1/1",
                  DATA, DATA_VALID, OVERRUN);
      end
      cyc(0, 1, 0, 1);
      checks++;
      if (DATA_VALID !== 1'b0 || OVERRUN !== 1'b1 || DATA !== 8'd3) begin
         failures++;
         $display("FAIL ovr_transfer valid=%b ovr=%b data=%0d required 0/1/3",
                  DATA_VALID, OVERRUN, DATA);
      end
   endtask

   task automatic test_deadtime();
      int exp_dt = exp_regular(10, 4);
      int vdata  = -1;
      do_reset();
      cyc(0, 1, 0, 1);
      for (int k = 1; k <= W + 3; k++) begin
         cyc(0, 1, train(k, 5, 10, 4, 2), 1);
         checks++;
         if (DATA_VALID !== m_valid || OVERRUN !== m_over || DATA !== 8'(m_data)) begin
            failures++;
            $display("FAIL dt_model k=%0d valid=%b/%b data=%0d/%0d ovr=%b/%b (actual/required)",
                     k, DATA_VALID, m_valid, DATA, m_data, OVERRUN, m_over);
         end
         if (k == W && DATA_VALID === 1'b1) vdata = DATA;
      end
      checks++;
      if (vdata != exp_dt) begin
         failures++;
         $display("FAIL dt_count data=%0d required %0d", vdata, exp_dt);
      end
   endtask

   task automatic test_enable_drop();
      int nvalid = 0;
      int vk     = -1;
      int vdata  = -1;
      do_reset();
      cyc(0, 1, 0, 1);
      for (int k = 1; k <= 130; k++) begin
         cyc(0, (k < 50), train(k, 5, 6, 7, 2), 1);
         if (DATA_VALID === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 0) begin
         failures++;
         $display("FAIL en_drop_no_word words=%0d required 0", nvalid);
      end
      cyc(0, 1, 0, 1);
      for (int k = 1; k <= W + 2; k++) begin
         cyc(0, 1, train(k, 10, 2, 10, 2), 1);
         checks++;
         if (DATA_VALID !== m_valid || OVERRUN !== m_over || DATA !== 8'(m_data)) begin
            failures++;
            $display("FAIL en_model k=%0d valid=%b/%b data=%0d/%0d ovr=%b/%b (actual/required)",
                     k, DATA_VALID, m_valid, DATA, m_data, OVERRUN, m_over);
         end
         if (DATA_VALID === 1'b1 && vk < 0) begin
            vk = k; vdata = DATA;
         end
      end
      checks++;
      if (vk != W || vdata != 2) begin
         failures++;
         $display("FAIL en_fresh_window at=%0d data=%0d required %0d/2", vk, vdata, W);
      end
   endtask

   task automatic test_reset_mid();
      int vk    = -1;
      int vdata = -1;
      do_reset();
      cyc(0, 1, 0, 0);
      for (int k = 1; k < W + 60; k++) cyc(0, 1, train(k, 10, 4, 10, 2), 0);
      cyc(1, 1, 0, 1);
      checks++;
      if (DATA !== 8'd0 || DATA_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset data=%0d valid=%b ovr=%b required 0/0/0",
                  DATA, DATA_VALID, OVERRUN);
      end
      cyc(0, 1, 0, 1);
      for (int k = 1; k <= W + 2; k++) begin
         cyc(0, 1, 0, 1);
         if (DATA_VALID === 1'b1 && vk < 0) begin
            vk = k; vdata = DATA;
         end
      end
      checks++;
      if (vk != W || vdata != 0) begin
         failures++;
         $display("FAIL mid_reset_idle at=%0d data=%0d required %0d/0", vk, vdata, W);
      end
   endtask

   task automatic test_random();
      bit en   = 1;
      bit disc = 0;
      int hold = 0;
      bit rdy;
      bit rst;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(299) == 0) en = ~en;
         if (hold == 0) begin
            disc = ~disc;
            hold = $urandom_range(6, 1);
         end
         hold--;
         rdy = ((k / 250) % 2 == 0) ? 1'b0 : ($urandom_range(3) != 0);
         rst = ($urandom_range(999) == 0);
         cyc(rst, en, disc, rdy);
         checks++;
         if (DATA_VALID !== m_valid || OVERRUN !== m_over || DATA !== 8'(m_data)) begin
            failures++;
            $display("FAIL rand_model k=%0d valid=%b/%b data=%0d/%0d ovr=%b/%b (actual/required)",
                     k, DATA_VALID, m_valid, DATA, m_data, OVERRUN, m_over);
         end
      end
   endtask

   initial begin
      RST = 1'b1; ENABLE = 1'b0; DISC = 1'b0; DATA_READY = 1'b0;
      test_reset();
      test_clean_pulses();
      test_saturation();
      test_overrun();
      test_deadtime();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
